// File: rtl/run_monitor.sv
// run_monitor: sequences the core reset, then counts run cycles and retired
// instructions until the first of halt (self-loop), deadlock (retire stall)
// or timeout ends the run. Results stay frozen until the next reset.
module run_monitor #(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 5000,
    parameter int unsigned STALL_LIMIT  = 64,
    parameter int unsigned HALT_REPEAT  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 retire_valid,
    input  logic [PC_WIDTH-1:0]  retire_pc,
    output logic                 core_reset,
    output logic                 running,
    output logic                 done,
    output logic [1:0]           status,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retire_count,
    output logic [PC_WIDTH-1:0]  last_pc
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        STS_NONE     = 2'b00,
        STS_HALT     = 2'b01,
        STS_DEADLOCK = 2'b10,
        STS_TIMEOUT  = 2'b11
    } status_e;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CYCLE_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STALL_LAST  = CNT_WIDTH'(STALL_LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(HALT_REPEAT - 1);

    state_e                 state_q;
    status_e                status_q;
    logic                   core_reset_q;
    logic                   running_q;
    logic                   done_q;
    logic [CNT_WIDTH-1:0]   cycle_count_q;
    logic [CNT_WIDTH-1:0]   retire_count_q;
    logic [PC_WIDTH-1:0]    last_pc_q;
    logic [CNT_WIDTH-1:0]   hold_cnt_q;
    logic [CNT_WIDTH-1:0]   stall_cnt_q;
    logic [CNT_WIDTH-1:0]   repeat_cnt_q;
    logic                   have_retire_q;

    logic                   pc_match_d;
    logic                   halt_d;
    logic                   deadlock_d;
    logic                   timeout_d;
    logic                   finish_d;
    status_e                status_d;

    // Termination detection on current-cycle values, halt > deadlock > timeout
    always_comb begin
        pc_match_d = have_retire_q && (retire_pc == last_pc_q);
        halt_d     = retire_valid && pc_match_d && (repeat_cnt_q == REPEAT_LAST);
        deadlock_d = !retire_valid && (stall_cnt_q == STALL_LAST);
        timeout_d  = (cycle_count_q == CYCLE_LAST);
        finish_d   = halt_d || deadlock_d || timeout_d;
        status_d   = STS_NONE;
        if (halt_d) begin
            status_d = STS_HALT;
        end else if (deadlock_d) begin
            status_d = STS_DEADLOCK;
        end else if (timeout_d) begin
            status_d = STS_TIMEOUT;
        end
    end

    // Run-control FSM with all counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_HOLD;
            status_q       <= STS_NONE;
            core_reset_q   <= 1'b1;
            running_q      <= 1'b0;
            done_q         <= 1'b0;
            cycle_count_q  <= '0;
            retire_count_q <= '0;
            last_pc_q      <= '0;
            hold_cnt_q     <= '0;
            stall_cnt_q    <= '0;
            repeat_cnt_q   <= '0;
            have_retire_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    hold_cnt_q <= hold_cnt_q + 1'b1;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q      <= ST_RUN;
                        core_reset_q <= 1'b0;
                        running_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cycle_count_q <= cycle_count_q + 1'b1;
                    if (retire_valid) begin
                        if (retire_count_q != '1) begin
                            retire_count_q <= retire_count_q + 1'b1;
                        end
                        last_pc_q     <= retire_pc;
                        have_retire_q <= 1'b1;
                        stall_cnt_q   <= '0;
                        if (pc_match_d) begin
                            repeat_cnt_q <= repeat_cnt_q + 1'b1;
                        end else begin
                            repeat_cnt_q <= CNT_WIDTH'(1);
                        end
                    end else begin
                        stall_cnt_q <= stall_cnt_q + 1'b1;
                    end
                    if (finish_d) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        running_q <= 1'b0;
                        status_q  <= status_d;
                    end
                end
                default: begin
                    // DONE: everything frozen until reset
                end
            endcase
        end
    end

    assign core_reset   = core_reset_q;
    assign running      = running_q;
    assign done         = done_q;
    assign status       = status_q;
    assign cycle_count  = cycle_count_q;
    assign retire_count = retire_count_q;
    assign last_pc      = last_pc_q;

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
Parametrised run controller for the pipeline simulation harness and FPGA bring-up, replacing the fixed reset pulse and fixed-time finish. It sequences the core reset and counts cycles and retired instructions. It ends the run on the first of three events: self-loop halt, retire stall (deadlock), or cycle timeout. It sits beside MIPS_top, drives its reset, and observes the writeback/retire stage.

Parameters:
PC_WIDTH, 32, width of retired PC
CNT_WIDTH, 32, width of cycle/retire counters; must hold MAX_CYCLES
RESET_CYCLES, 2, cycles core_reset is held after reset deasserts (>=1)
MAX_CYCLES, 5000, RUN-cycle budget before timeout (>=1)
STALL_LIMIT, 64, consecutive RUN cycles without retire that flag deadlock (>=1)
HALT_REPEAT, 3, consecutive retires of the same PC that flag halt (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; restarts the whole sequence
retire_valid  in  1  one instruction retired this cycle
retire_pc  in  PC_WIDTH  PC of the retiring instruction, valid with retire_valid
core_reset  out  1  synchronous active-high reset to the core
running  out  1  high in RUN state
done  out  1  run finished; sticky until reset
status  out  2  00 none, 01 halt, 10 deadlock, 11 timeout
cycle_count  out  CNT_WIDTH  RUN cycles elapsed
retire_count  out  CNT_WIDTH  instructions retired in RUN, saturating
last_pc  out  PC_WIDTH  PC of most recent retire

Behaviour:
- All outputs are registered. The block is synchronous to clk only.
- Reset value when reset=1 at an edge:
  - state HOLD, core_reset=1, running=0, done=0, status=00.
  - cycle_count, retire_count, last_pc, hold/stall/repeat counters all 0.
  - Reset asserted in any state, including mid-RUN or DONE, restarts fully on the next edge.
- HOLD state:
  - hold_cnt increments each edge.
  - At the edge where hold_cnt==RESET_CYCLES-1: go to RUN, core_reset<=0, running<=1.
  - core_reset is therefore high for exactly RESET_CYCLES edges after the first edge with reset=0.
  - retire inputs are ignored.
- RUN state, per edge:
  - cycle_count += 1.
  - If retire_valid: retire_count += 1 (saturates at all-ones), last_pc<=retire_pc, stall_cnt<=0.
    - If retire_pc equals the stored last_pc and a prior retire exists: repeat_cnt += 1.
    - Otherwise repeat_cnt<=1.
  - If no retire: stall_cnt += 1; repeat_cnt unchanged.
- Termination conditions, evaluated on current-cycle values before update:
  - halt: retire_valid, retire_pc==last_pc, and repeat_cnt==HALT_REPEAT-1.
  - deadlock: !retire_valid and stall_cnt==STALL_LIMIT-1.
  - timeout: cycle_count==MAX_CYCLES-1.
- On any termination at an edge: state<=DONE, done<=1, running<=0, status set. Counter updates for that edge still apply, so final cycle_count==MAX_CYCLES on timeout.
- Simultaneous events use priority halt > deadlock > timeout.
- DONE state: all counters, last_pc and status frozen. core_reset stays 0. Inputs ignored. Leave only via reset.
- The first retire after HOLD never matches; the stored last_pc of 0 is not valid.

Test Plan:
- Overrides RESET_CYCLES=4, MAX_CYCLES=20, STALL_LIMIT=5, HALT_REPEAT=3. reset high 3 edges then low -> core_reset high for 4 further edges; running=1 on the 5th edge; cycle_count=0 at that point.
- RUN, retire_valid=1 every cycle with PC 0,4,8,12,12,12 -> done on the edge of the third 12; status=01, last_pc=12, retire_count=6, cycle_count=6.
- RUN, retire PCs 0,4 then retire_valid=0 -> done after 5 idle edges; status=10, cycle_count=7, retire_count=2, last_pc=4.
- RUN, retire every other cycle with incrementing PCs -> status=11 at cycle_count=20, done=1; counters hold for 10 further edges.
- PC sequence 8,8,4,8,8 (no third consecutive 8) -> no halt. Then at cycle 19 retire the third consecutive PC, coinciding with timeout -> status=01 (halt priority).
- reset pulsed for 1 edge mid-RUN at cycle_count=9 -> all outputs return to reset values; HOLD repeats for 4 edges; cycle_count restarts from 0.
